// File: rtl/ioctl_pkg.sv
// Shared definitions for the ioctl download path: opcodes, default load
// addresses and the RAM writer state encoding.
package ioctl_pkg;

  localparam logic [7:0] UIO_FILE_TX     = 8'h53;
  localparam logic [7:0] UIO_FILE_TX_DAT = 8'h54;
  localparam logic [7:0] UIO_FILE_INDEX  = 8'h55;

  localparam logic [24:0] LOAD_BASE_0 = 25'h0E0000;
  localparam logic [24:0] LOAD_BASE_1 = 25'h100000;
  localparam logic [24:0] LOAD_BASE_2 = 25'h120000;

  typedef enum logic [1:0] {IDLE, REQ, GAP} wr_state_t;

  // Default byte base address for a menu index; unknown indices use slot 0.
  function automatic logic [24:0] load_base(input logic [4:0] idx);
    case (idx)
      5'd1:    return LOAD_BASE_1;
      5'd2:    return LOAD_BASE_2;
      default: return LOAD_BASE_0;
    endcase
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock circular FIFO; pointers carry an extra wrap bit so full and
// empty fall straight out of a pointer compare.
module sync_fifo #(
  parameter int DW = 40,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout,
  output logic          full,
  output logic          empty
);

  logic [DW-1:0] mem [2**AW];
  logic [AW:0]   wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/ioctl_ram_writer.sv
// Turns ioctl download strobes into buffered 16-bit memory writes and tracks
// per-load bookkeeping (index, byte size, overflow, start/done).
module ioctl_ram_writer
  import ioctl_pkg::*;
#(
  parameter int FIFO_AW = 4,
  parameter int ADDR_W  = 25
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              ioctl_download,
  input  logic [4:0]        ioctl_index,
  input  logic              ioctl_we,
  input  logic [ADDR_W-1:0] ioctl_addr,
  input  logic [15:0]       ioctl_dout,
  output logic              mem_req,
  output logic [ADDR_W-2:0] mem_addr,
  output logic [15:0]       mem_dout,
  input  logic              mem_ack,
  output logic              load_active,
  output logic              load_done,
  output logic [4:0]        load_index,
  output logic [ADDR_W-1:0] load_size,
  output logic              overflow
);

  localparam int DW = ADDR_W - 1 + 16;

  logic          we_d, dl_d;
  logic          push, pop, accept, drop, dl_rise;
  logic          fifo_full, fifo_empty;
  logic [DW-1:0] fifo_dout;
  logic          unused_addr_lsb;
  wr_state_t     state;

  assign unused_addr_lsb = ioctl_addr[0];

  assign push    = ioctl_we & ~we_d;
  assign accept  = push & ~fifo_full;
  assign drop    = push & fifo_full;
  assign dl_rise = ioctl_download & ~dl_d;
  assign pop     = (state == REQ) & mem_ack;

  sync_fifo #(.DW(DW), .AW(FIFO_AW)) u_fifo (
    .clk   (clk_sys),
    .rst_n (reset_n),
    .push  (push),
    .pop   (pop),
    .din   ({ioctl_addr[ADDR_W-1:1], ioctl_dout}),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Load bookkeeping. A restart keeps load_active high, so the previous
  // load's done pulse is naturally absorbed into the new load.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      we_d        <= 1'b0;
      dl_d        <= 1'b0;
      load_active <= 1'b0;
      load_done   <= 1'b0;
      load_index  <= '0;
      load_size   <= '0;
      overflow    <= 1'b0;
    end else begin
      we_d      <= ioctl_we;
      dl_d      <= ioctl_download;
      load_done <= 1'b0;
      if (dl_rise) begin
        load_index  <= ioctl_index;
        load_active <= 1'b1;
        load_size   <= accept ? ADDR_W'(2) : '0;
        overflow    <= drop;
      end else begin
        if (accept) load_size <= load_size + ADDR_W'(2);
        if (drop)   overflow  <= 1'b1;
        if (load_active && !dl_d && fifo_empty && state == IDLE) begin
          load_done   <= 1'b1;
          load_active <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      mem_req  <= 1'b0;
      mem_addr <= '0;
      mem_dout <= '0;
    end else begin
      case (state)
        IDLE: if (!fifo_empty) begin
          mem_addr <= fifo_dout[DW-1:16];
          mem_dout <= fifo_dout[15:0];
          mem_req  <= 1'b1;
          state    <= REQ;
        end
        REQ: if (mem_ack) begin
          mem_req <= 1'b0;
          state   <= GAP;
        end
        GAP:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ioctl_ram_writer.sv
// Directed bench for ioctl_ram_writer with a simple acking memory model.
module tb_ioctl_ram_writer;

  localparam int ADDR_W  = 25;
  localparam int FIFO_AW = 4;

  logic              clk_sys = 1'b0;
  logic              reset_n = 1'b0;
  logic              ioctl_download = 1'b0;
  logic [4:0]        ioctl_index = '0;
  logic              ioctl_we = 1'b0;
  logic [ADDR_W-1:0] ioctl_addr = '0;
  logic [15:0]       ioctl_dout = '0;
  logic              mem_req;
  logic [ADDR_W-2:0] mem_addr;
  logic [15:0]       mem_dout;
  logic              mem_ack;
  logic              load_active, load_done, overflow;
  logic [4:0]        load_index;
  logic [ADDR_W-1:0] load_size;

  logic        resp_ack = 1'b0;
  logic        force_ack = 1'b0;
  bit          ack_en = 1'b0;
  int          ack_dly = 1;
  logic [39:0] wr_log[$];
  int          done_cnt = 0;
  int          req_cyc = 0;
  int          n_cmp = 0;
  int          n_bad = 0;

  assign mem_ack = resp_ack | force_ack;

  always #5 clk_sys = ~clk_sys;

  ioctl_ram_writer #(.FIFO_AW(FIFO_AW), .ADDR_W(ADDR_W)) u_dut (
    .clk_sys        (clk_sys),
    .reset_n        (reset_n),
    .ioctl_download (ioctl_download),
    .ioctl_index    (ioctl_index),
    .ioctl_we       (ioctl_we),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .mem_req        (mem_req),
    .mem_addr       (mem_addr),
    .mem_dout       (mem_dout),
    .mem_ack        (mem_ack),
    .load_active    (load_active),
    .load_done      (load_done),
    .load_index     (load_index),
    .load_size      (load_size),
    .overflow       (overflow)
  );

  // Memory model: acks ack_dly cycles into a request and logs the write.
  initial begin : responder
    int wc;
    wc = 0;
    forever begin
      @(negedge clk_sys);
      if (ack_en && mem_req && reset_n) begin
        wc++;
        if (wc >= ack_dly) begin
          wr_log.push_back({mem_addr, mem_dout});
          resp_ack = 1'b1;
          @(negedge clk_sys);
          resp_ack = 1'b0;
          wc = 0;
        end
      end else begin
        wc = 0;
      end
    end
  end

  initial begin : monitor
    forever begin
      @(negedge clk_sys);
      if (load_done) done_cnt++;
      if (mem_req)   req_cyc++;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  task automatic strobe(input logic [24:0] a, input logic [15:0] d);
    @(posedge clk_sys); #1;
    ioctl_addr = a;
    ioctl_dout = d;
    ioctl_we   = 1'b1;
    @(posedge clk_sys); #1;
    @(posedge clk_sys); #1;
    ioctl_we   = 1'b0;
  endtask

  task automatic dl_start(input logic [4:0] idx);
    tick(1);
    ioctl_index    = idx;
    ioctl_download = 1'b1;
    tick(2);
  endtask

  task automatic wait_req(input string tag);
    int n;
    n = 0;
    while (!mem_req && n < 100) begin tick(1); n++; end
    chk(tag, mem_req, 1);
  endtask

  task automatic wait_done(input string tag, input int target);
    int n;
    n = 0;
    while (done_cnt < target && n < 300) begin tick(1); n++; end
    chk(tag, done_cnt, target);
  endtask

  task automatic wait_log(input string tag, input int target);
    int n;
    n = 0;
    while (wr_log.size() < target && n < 300) begin tick(1); n++; end
    chk(tag, wr_log.size(), target);
  endtask

  initial begin : stim
    int d0, r0;
    logic [39:0] e;

    // Reset state
    tick(3);
    chk("rst_req",    mem_req, 0);
    chk("rst_active", load_active, 0);
    chk("rst_size",   load_size, 0);
    chk("rst_ovf",    overflow, 0);
    reset_n = 1'b1;
    tick(2);

    // Single word
    ack_en = 1'b1; ack_dly = 3; d0 = done_cnt;
    dl_start(5'd0);
    strobe(25'h0E0000, 16'hA55A);
    wait_req("t1_req");
    chk("t1_addr", mem_addr, 24'h070000);
    chk("t1_dout", mem_dout, 16'hA55A);
    ioctl_download = 1'b0;
    wait_done("t1_done", d0 + 1);
    chk("t1_size",   load_size, 2);
    chk("t1_index",  load_index, 0);
    chk("t1_active", load_active, 0);
    chk("t1_nlog",   wr_log.size(), 1);
    chk("t1_log",    wr_log[0], {24'h070000, 16'hA55A});
    tick(10);
    chk("t1_once",   done_cnt, d0 + 1);

    // Stall and overflow
    ack_en = 1'b0; wr_log.delete();
    dl_start(5'd2);
    for (int i = 0; i < 16; i++) strobe(25'h100000 + 25'(2*i), 16'h1000 + 16'(i));
    chk("t2_ovf_pre", overflow, 0);
    strobe(25'h100020, 16'hDEAD);
    tick(2);
    chk("t2_ovf",  overflow, 1);
    chk("t2_size", load_size, 32);
    d0 = done_cnt; ack_dly = 1; ack_en = 1'b1;
    ioctl_download = 1'b0;
    wait_done("t2_done", d0 + 1);
    chk("t2_nlog", wr_log.size(), 16);
    for (int i = 0; i < 16 && i < wr_log.size(); i++) begin
      e = {24'h080000 + 24'(i), 16'h1000 + 16'(i)};
      chk($sformatf("t2_wr%0d", i), wr_log[i], e);
    end

    // Push on the exact cycle of the ack
    ack_en = 1'b0; wr_log.delete();
    dl_start(5'd4);
    chk("t3_ovf_clr",  overflow, 0);
    chk("t3_size_clr", load_size, 0);
    strobe(25'h0E0010, 16'h1111);
    wait_req("t3_reqA");
    chk("t3_addrA", mem_addr, 24'h070008);
    @(posedge clk_sys); #1;
    ioctl_addr = 25'h0E0012; ioctl_dout = 16'h2222;
    ioctl_we = 1'b1; force_ack = 1'b1;
    @(posedge clk_sys); #1;
    force_ack = 1'b0;
    @(posedge clk_sys); #1;
    ioctl_we = 1'b0;
    ack_dly = 3; ack_en = 1'b1; d0 = done_cnt;
    wait_req("t3_reqB");
    chk("t3_addrB", mem_addr, 24'h070009);
    chk("t3_doutB", mem_dout, 16'h2222);
    ioctl_download = 1'b0;
    wait_done("t3_done", d0 + 1);
    chk("t3_nlog", wr_log.size(), 1);
    chk("t3_size", load_size, 4);

    // Restart while the previous load drains
    ack_en = 1'b0; wr_log.delete();
    dl_start(5'd3);
    for (int i = 0; i < 5; i++) strobe(25'h120000 + 25'(2*i), 16'h3000 + 16'(i));
    ioctl_download = 1'b0;
    tick(3);
    d0 = done_cnt;
    ioctl_index = 5'd1; ioctl_download = 1'b1;
    tick(2);
    chk("t4_index",  load_index, 1);
    chk("t4_size",   load_size, 0);
    chk("t4_active", load_active, 1);
    ack_dly = 1; ack_en = 1'b1;
    wait_log("t4_nlog", 5);
    tick(10);
    chk("t4_nodone", done_cnt, d0);
    for (int i = 0; i < 5 && i < wr_log.size(); i++) begin
      e = {24'h090000 + 24'(i), 16'h3000 + 16'(i)};
      chk($sformatf("t4_wr%0d", i), wr_log[i], e);
    end
    ioctl_download = 1'b0;
    wait_done("t4_done", d0 + 1);
    chk("t4_size_end", load_size, 0);

    // Async reset in the middle of a request
    ack_en = 1'b0; wr_log.delete();
    dl_start(5'd5);
    strobe(25'h0E0020, 16'h5555);
    wait_req("t5_req");
    @(posedge clk_sys); #3;
    reset_n = 1'b0; ioctl_download = 1'b0;
    #1;
    chk("t5_req0",    mem_req, 0);
    chk("t5_active0", load_active, 0);
    chk("t5_index0",  load_index, 0);
    chk("t5_size0",   load_size, 0);
    chk("t5_addr0",   mem_addr, 0);
    #10 reset_n = 1'b1;
    tick(1);
    force_ack = 1'b1;
    tick(1);
    force_ack = 1'b0;
    r0 = req_cyc;
    tick(6);
    chk("t5_noreq",  req_cyc, r0);
    chk("t5_active", load_active, 0);
    chk("t5_done",   load_done, 0);

    // Empty load
    ack_en = 1'b1; r0 = req_cyc; d0 = done_cnt;
    dl_start(5'd6);
    ioctl_download = 1'b0;
    wait_done("t6_done", d0 + 1);
    tick(5);
    chk("t6_once",   done_cnt, d0 + 1);
    chk("t6_size",   load_size, 0);
    chk("t6_index",  load_index, 6);
    chk("t6_noreq",  req_cyc, r0);
    chk("t6_active", load_active, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ioctl_ram_writer.md
Name: ioctl_ram_writer

Overview:
- Downstream consumer of the ioctl download port: ioctl_download, ioctl_index, ioctl_we, ioctl_addr, ioctl_dout.
- Turns each ioctl write strobe into exactly one 16-bit word write.
- Buffers writes in a small FIFO so a slow memory controller (SDRAM port with req/ack) can stall without losing data.
- Reports start/end of each load, its index, its size in bytes, and a sticky overflow flag to the core (ROM/cart loader, reset sequencer).

Parameters:
- FIFO_AW, 4, log2 of FIFO depth (default 16 entries).
- ADDR_W, 25, byte address width of ioctl_addr; word address is ADDR_W-1 bits.

Ports:
- clk_sys  in  1  system clock, same clock that samples ioctl_we.
- reset_n  in  1  asynchronous active-low reset.
- ioctl_download  in  1  download active.
- ioctl_index  in  5  menu index of the file.
- ioctl_we  in  1  write strobe, level high for 2 clk_sys cycles per word.
- ioctl_addr  in  ADDR_W  byte address, bit 0 always 0 during writes.
- ioctl_dout  in  16  data word, low byte at even address.
- mem_req  out  1  write request to memory controller.
- mem_addr  out  ADDR_W-1  word address (ioctl_addr[ADDR_W-1:1]).
- mem_dout  out  16  write data.
- mem_ack  in  1  one-cycle pulse: current request is complete.
- load_active  out  1  high from download start until FIFO fully drained.
- load_done  out  1  one-cycle pulse after the last word is written.
- load_index  out  5  ioctl_index latched at download start.
- load_size  out  ADDR_W  bytes accepted into the FIFO (2 × words).
- overflow  out  1  sticky: a write arrived while the FIFO was full.

Behaviour:
- Reset (async, any time): all outputs 0; FIFO emptied; FSM to IDLE; mem_req drops immediately. No write completes if reset lands mid-request.
- Strobe detect: register we_d <= ioctl_we; push = ioctl_we & ~we_d, so exactly one push per strobe. Back-to-back strobes need at least one low cycle between them.
- FIFO entry: {ioctl_addr[ADDR_W-1:1], ioctl_dout}, captured in the push cycle.
- FIFO is a circular buffer with FIFO_AW-bit pointers plus a wrap bit; full and empty are derived from the pointers.
- Simultaneous push and pop are allowed, and the count is unchanged.
- Push while full: entry dropped, overflow set to 1, load_size not incremented.
- Download start (rising edge of ioctl_download, registered as dl_d):
  - load_index <= ioctl_index; load_size <= 0; overflow <= 0; load_active <= 1.
  - This applies even if entries from a previous load are still draining: those entries are still written, but their load_done is suppressed.
- load_size increments by 2 per accepted push and wraps modulo 2^ADDR_W.
- Memory FSM:
  - IDLE: if FIFO not empty, present the head on mem_addr/mem_dout, mem_req <= 1, go to REQ.
  - REQ: mem_req, mem_addr and mem_dout are held stable. On mem_ack: pop, mem_req <= 0, go to GAP.
  - GAP: one cycle with mem_req low, then IDLE.
  - Latency: push registered at edge E0, mem_req high after E1. Throughput is at most one word per 3 cycles plus memory latency.
  - mem_ack outside REQ is ignored.
- Completion: when dl_d == 0, FIFO empty, FSM in IDLE and load_active == 1:
  - load_done pulses for 1 cycle; load_active <= 0 on the same edge.
- A download with zero writes still produces load_done once ioctl_download falls; load_size = 0.
- ioctl_addr/ioctl_index are only sampled at push and download start. Changes while ioctl_download is low are ignored.

Decomposition:
- Shared package ioctl_pkg:
  - UIO_FILE_TX/TX_DAT/INDEX opcode constants.
  - Default load base addresses per index (0x0E0000, 0x100000, 0x120000).
  - Enum for writer states (IDLE, REQ, GAP).
- One sub-module, sync_fifo (params DW, AW; ports push, pop, din, dout, full, empty), instantiated with DW = ADDR_W-1+16.
- The FSM, strobe detection and load bookkeeping stay in the top module.

Test Plan:
- Single word: download=1 at index 0, one 2-cycle strobe with addr 0x0E0000, data 0xA55A, mem_ack 3 cycles after req.
  - Expect mem_req with mem_addr 0x070000, mem_dout 0xA55A; load_done pulse after ack; load_size 2; load_index 0.
- Stall: 16 strobes with mem_ack withheld, then 1 more strobe.
  - Expect overflow 1 and load_size 32.
  - After acks are released, 16 writes occur in order with consecutive word addresses.
- Push/pop collision: a strobe on the exact cycle of mem_ack with 1 entry queued.
  - Expect the count to stay 1 and the next request to carry the new word.
- Restart while draining: download falls with 5 entries queued, then rises again before drain completes (index 1).
  - Expect all 5 entries still written, no load_done for the first load, load_index 1, load_size 0.
- Async reset during REQ: assert reset_n=0 mid-request.
  - Expect mem_req 0 within the same cycle, all outputs 0, FIFO empty after release; a spurious mem_ack is ignored.
- Empty load: download pulse with no strobes.
  - Expect one load_done pulse, load_size 0, no mem_req.
